// File: rtl/micro_sequencer.sv
// Micro-program sequencer: latches an instruction, walks its 4-word micro-ROM routine
// and presents registered microwords downstream. Optional MICRO_SEQ_RETIRE_COUNT_EN adds a retired-routine counter.
module micro_sequencer #(
    parameter int INSTR_W = 22,
    parameter int UWORD_W = 33,
    parameter int UADDR_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [UADDR_W-1:0] uaddr,
    input  logic [UWORD_W-1:0] uword,
    output logic [UWORD_W-1:0] Q,
    output logic [INSTR_W-1:0] instruction,
    output logic               uvalid,
`ifdef MICRO_SEQ_RETIRE_COUNT_EN
    output logic [15:0]        retired,
`endif
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t               r_state;
    logic [UWORD_W-1:0]   r_q;
    logic [INSTR_W-1:0]   r_instr;
    logic [UADDR_W-1:0]   r_uaddr;
    logic                 r_uvalid;
    logic                 r_halted;
    logic                 r_ready;
`ifdef MICRO_SEQ_RETIRE_COUNT_EN
    logic [15:0]          r_retired;
`endif

    logic                 w_end;
    logic                 w_halt;
    logic                 w_last;
    logic [UADDR_W-1:0]   w_base;

    assign w_end  = uword[UWORD_W-1];
    assign w_halt = uword[UWORD_W-2];
    // Slot 3 forces the end so a routine never runs into the next opcode's slot.
    assign w_last = w_end | (r_uaddr[1:0] == 2'b11);
    assign w_base = UADDR_W'({instr_in[INSTR_W-1 -: 4], 2'b00});

    // Sequencer state machine with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_q       <= '0;
            r_instr   <= '0;
            r_uaddr   <= '0;
            r_uvalid  <= 1'b0;
            r_halted  <= 1'b0;
            r_ready   <= 1'b1;
`ifdef MICRO_SEQ_RETIRE_COUNT_EN
            r_retired <= 16'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_uvalid <= 1'b0;
                    if (instr_valid) begin
                        r_instr <= instr_in;
                        r_uaddr <= w_base;
                        r_ready <= 1'b0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_q      <= uword;
                    r_uvalid <= 1'b1;
                    if (!w_last) begin
                        r_uaddr <= r_uaddr + UADDR_W'(1);
                    end
                    if (w_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (w_last) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
`ifdef MICRO_SEQ_RETIRE_COUNT_EN
                        r_retired <= r_retired + 16'd1;
`endif
                    end
                end
                ST_HALT: begin
                    r_uvalid <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_uvalid <= 1'b0;
                    r_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign Q           = r_q;
    assign instruction = r_instr;
    assign uaddr       = r_uaddr;
    assign uvalid      = r_uvalid;
    assign halted      = r_halted;
    assign instr_ready = r_ready;
`ifdef MICRO_SEQ_RETIRE_COUNT_EN
    assign retired     = r_retired;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: a schedule-level model of each routine
// drives per-cycle expectations, checked on every falling edge.
module tb_micro_sequencer;

    logic        clk;
    logic        reset;
    logic [21:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  uaddr;
    logic [32:0] uword;
    logic [32:0] Q;
    logic [21:0] instruction;
    logic        uvalid;
    logic        halted;
`ifdef MICRO_SEQ_RETIRE_COUNT_EN
    logic [15:0] retired;
`endif

    logic [32:0] rom [64];
    assign uword = rom[uaddr];

    micro_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .uaddr       (uaddr),
        .uword       (uword),
        .Q           (Q),
        .instruction (instruction),
        .uvalid      (uvalid),
`ifdef MICRO_SEQ_RETIRE_COUNT_EN
        .retired     (retired),
`endif
        .halted      (halted)
    );

    int tests = 0;
    int fails = 0;

    logic [32:0] exp_q;
    logic [21:0] exp_instr;
    logic [5:0]  exp_uaddr;
    logic        exp_uvalid;
    logic        exp_halted;
    logic        exp_ready;
    logic [15:0] exp_retired;
    time         acc_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("Q", 64'(Q), 64'(exp_q));
        chk("instruction", 64'(instruction), 64'(exp_instr));
        chk("uaddr", 64'(uaddr), 64'(exp_uaddr));
        chk("uvalid", 64'(uvalid), 64'(exp_uvalid));
        chk("halted", 64'(halted), 64'(exp_halted));
        chk("instr_ready", 64'(instr_ready), 64'(exp_ready));
`ifdef MICRO_SEQ_RETIRE_COUNT_EN
        chk("retired", 64'(retired), 64'(exp_retired));
`endif
    end

    task automatic set_reset_exp();
        exp_q = '0; exp_instr = '0; exp_uaddr = '0; exp_uvalid = 1'b0;
        exp_halted = 1'b0; exp_ready = 1'b1; exp_retired = '0;
    endtask

    // Assert reset a few ns after an edge, hold 2 edges, release.
    task automatic apply_reset();
        #2;
        reset = 1'b1;
        set_reset_exp();
        #1;
        chk("rst_Q", 64'(Q), 64'd0);
        chk("rst_uaddr", 64'(uaddr), 64'd0);
        chk("rst_uvalid", 64'(uvalid), 64'd0);
        chk("rst_ready", 64'(instr_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 exp_uvalid = 1'b0;
        end
    endtask

    // Expected routine: words from base upward, stopping at END, HALT or slot 3.
    task automatic run_instr(input logic [21:0] ins, input bit keep);
        logic [5:0]  addrs [4];
        logic [32:0] w;
        int          n;
        bit          hlt;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            addrs[k] = {ins[21:18], 2'b00} + 6'(k);
            n = k + 1;
            w = rom[addrs[k]];
            if (w[32] || w[31] || k == 3) break;
        end
        w = rom[addrs[n-1]];
        hlt = w[31];
        instr_in = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_t = $time;
        if (!keep) instr_valid = 1'b0;
        exp_instr = ins; exp_uaddr = addrs[0]; exp_uvalid = 1'b0; exp_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exp_q = rom[addrs[i]];
            exp_uvalid = 1'b1;
            if (i < n - 1) begin
                exp_uaddr = addrs[i+1];
            end else if (hlt) begin
                exp_halted = 1'b1;
                if (!(w[32] || i == 3)) exp_uaddr = addrs[i] + 6'd1;
            end else begin
                exp_ready = 1'b1;
                exp_retired = exp_retired + 16'd1;
            end
        end
    endtask

    initial begin
        time t1;
        for (int i = 0; i < 64; i++) rom[i] = {1'b1, 1'b0, 31'(i * 32'h01234577 ^ 32'h5A5A5A5)};
        rom[12] = 33'h0_1234_5678;
        rom[13] = 33'h1_0000_00AB;
        for (int i = 24; i < 28; i++) rom[i] = {2'b00, 31'(32'h0ABC0000 + i)};
        for (int i = 60; i < 64; i++) rom[i] = {2'b00, 31'(32'h0F0F0000 + i)};
        rom[8]  = 33'h1_8000_0008;
        rom[4]  = 33'h1_0000_0004;
        rom[20] = 33'h1_0000_0014;
        reset = 1'b1;
        instr_in = '0;
        instr_valid = 1'b0;
        set_reset_exp();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        // Reset mid-routine at uaddr 0x19.
        instr_in = 22'h180000; instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        exp_instr = 22'h180000; exp_uaddr = 6'd24; exp_ready = 1'b0;
        @(posedge clk); #1 exp_q = rom[24]; exp_uvalid = 1'b1; exp_uaddr = 6'd25;
        chk("mid_uaddr", 64'(uaddr), 64'h19);
        apply_reset();
        idle(4);

        // END on the second word.
        run_instr(22'h0C0025, 1'b0);
        chk("end2_Q", 64'(Q), 64'h1_0000_00AB);
        chk("end2_uaddr", 64'(uaddr), 64'd13);
        idle(2);

        // Forced end at slot 3, including the last ROM word.
        run_instr(22'h180001, 1'b0);
        chk("forced_uaddr", 64'(uaddr), 64'd27);
        idle(1);
        run_instr(22'h3C0002, 1'b0);
        chk("top_uaddr", 64'(uaddr), 64'd63);
        idle(2);

        // Back-to-back single-word routines with valid held high.
        run_instr(22'h040003, 1'b1);
        t1 = acc_t;
        run_instr(22'h140004, 1'b0);
        chk("b2b_spacing", 64'((acc_t - t1) / 10), 64'd2);
        chk("b2b_Q", 64'(Q), 64'h1_0000_0014);
        idle(2);

        // Three completed routines, then a HALT routine.
        @(posedge clk);
        apply_reset();
        idle(1);
        run_instr(22'h0C0005, 1'b0);
        run_instr(22'h180006, 1'b0);
        run_instr(22'h040007, 1'b0);
        idle(1);
        run_instr(22'h080008, 1'b0);
        chk("halt_flag", 64'(halted), 64'd1);
        instr_in = 22'h0C0009; instr_valid = 1'b1;
        idle(4);
        instr_valid = 1'b0;
        chk("halt_Q", 64'(Q), 64'h1_8000_0008);
        chk("halt_ready", 64'(instr_ready), 64'd0);
`ifdef MICRO_SEQ_RETIRE_COUNT_EN
        chk("retired_cnt", 64'(retired), 64'd3);
`endif
        apply_reset();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
